// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory SRAM port between the CPU MEM stage and the host loader: round-robin
// with starvation override, host bus lock, and tagged read-data return after RD_LAT cycles.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic              last_ext_q, last_ext_d;
  logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d, ext_wait_q, ext_wait_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_ext_q, tag_ext_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ext_rdata_q, ext_rdata_d;
  logic              grant_cpu, grant_ext, cpu_sat, ext_sat, out_vld;

  always_comb begin
    grant_cpu = 1'b0;
    grant_ext = 1'b0;
    cpu_sat   = (cpu_wait_q == WAIT_SAT);
    ext_sat   = (ext_wait_q == WAIT_SAT);
    if (!rst) begin
      if (state_q == ST_LOCKED) begin
        grant_ext = ext_req;
      end else if (cpu_req && ext_req) begin
        // A starved port beats the round-robin pointer; CPU is checked first.
        if (cpu_sat)      grant_cpu = 1'b1;
        else if (ext_sat) grant_ext = 1'b1;
        else if (last_ext_q) grant_cpu = 1'b1;
        else              grant_ext = 1'b1;
      end else begin
        grant_cpu = cpu_req;
        grant_ext = ext_req;
      end
    end
  end

  assign cpu_gnt   = grant_cpu;
  assign ext_gnt   = grant_ext;
  assign cpu_stall = cpu_req & ~grant_cpu;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:    if (grant_ext && ext_lock) state_d = ST_LOCKED;
      ST_LOCKED: if (!ext_lock) state_d = ST_ARB;
      default:   state_d = ST_ARB;
    endcase
    last_ext_d = last_ext_q;
    if (grant_cpu)      last_ext_d = 1'b0;
    else if (grant_ext) last_ext_d = 1'b1;
    cpu_wait_d = (!cpu_req || grant_cpu) ? '0 :
                 (cpu_sat ? cpu_wait_q : cpu_wait_q + WAIT_W'(1));
    ext_wait_d = (!ext_req || grant_ext) ? '0 :
                 (ext_sat ? ext_wait_q : ext_wait_q + WAIT_W'(1));
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (grant_cpu) begin
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant_ext) begin
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
  end

  // Tag pipe mirrors the SRAM read latency; the last stage says who owns mem_rdata now.
  always_comb begin
    tag_vld_d    = '0;
    tag_ext_d    = '0;
    tag_vld_d[0] = mem_ren;
    tag_ext_d[0] = grant_ext;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ext_d[i] = tag_ext_q[i-1];
    end
    out_vld     = tag_vld_q[RD_LAT-1] & ~rst;
    cpu_rvalid  = out_vld & ~tag_ext_q[RD_LAT-1];
    ext_rvalid  = out_vld & tag_ext_q[RD_LAT-1];
    cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    ext_rdata   = ext_rvalid ? mem_rdata : ext_rdata_q;
    cpu_rdata_d = cpu_rdata;
    ext_rdata_d = ext_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      last_ext_q  <= 1'b1;
      cpu_wait_q  <= '0;
      ext_wait_q  <= '0;
      tag_vld_q   <= '0;
      tag_ext_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_ext_q  <= last_ext_d;
      cpu_wait_q  <= cpu_wait_d;
      ext_wait_q  <= ext_wait_d;
      tag_vld_q   <= tag_vld_d;
      tag_ext_q   <= tag_ext_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: grant/stall/SRAM-mux checks against a rule-level arbiter model,
// read returns checked by a separate monitor popping per-port expected-data queues.
module tb_dmem_port_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_wen, ext_req, ext_wen, ext_lock;
  logic [ADDR_W-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata;
  logic              cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid, mem_wen, mem_ren;
  logic [DATA_W-1:0] cpu_rdata, ext_rdata;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM with RD_LAT-cycle read pipe; idle slots carry a poison value.
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    rd_pipe[0] <= mem_ren ? sram[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state.
  typedef struct { logic [DATA_W-1:0] data; int due; } exp_t;
  exp_t              cpu_q[$];
  exp_t              ext_q[$];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  bit                m_locked;
  int                m_last;     // 0 = CPU, 1 = host
  int                m_wait[2];
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  int                last_w;

  function automatic int pick(input bit cr, input bit er);
    if (m_locked) return er ? 1 : -1;
    if (cr && er) begin
      if (m_wait[0] >= MAX_WAIT) return 0;
      if (m_wait[1] >= MAX_WAIT) return 1;
      return 1 - m_last;
    end
    if (cr) return 0;
    if (er) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    cpu_q.delete();
    ext_q.delete();
    m_locked = 1'b0;
    m_last = 1;
    m_wait[0] = 0;
    m_wait[1] = 0;
    m_addr = '0;
    m_wdata = '0;
  endtask

  task automatic step(input bit cr, input bit cw, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                      input bit er, input bit ew, input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                      input bit el);
    int w;
    bit wr;
    exp_t e;
    @(negedge clk);
    cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed; ext_lock = el;
    #1;
    w = pick(cr, er);
    check("cpu_gnt", cpu_gnt, w == 0);
    check("ext_gnt", ext_gnt, w == 1);
    check("cpu_stall", cpu_stall, cr && (w != 0));
    if (w >= 0) begin
      wr = (w == 0) ? cw : ew;
      m_addr = (w == 0) ? ca : ea;
      m_wdata = (w == 0) ? cd : ed;
      if (wr) ref_mem[m_addr] = m_wdata;
      else begin
        e.data = ref_mem[m_addr];
        e.due = cyc + RD_LAT;
        if (w == 0) cpu_q.push_back(e); else ext_q.push_back(e);
      end
    end else wr = 1'b0;
    check("mem_wen", mem_wen, (w >= 0) && wr);
    check("mem_ren", mem_ren, (w >= 0) && !wr);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    if (w >= 0) m_last = w;
    m_wait[0] = (!cr || w == 0) ? 0 : ((m_wait[0] < MAX_WAIT) ? m_wait[0] + 1 : MAX_WAIT);
    m_wait[1] = (!er || w == 1) ? 0 : ((m_wait[1] < MAX_WAIT) ? m_wait[1] + 1 : MAX_WAIT);
    m_locked = m_locked ? el : (w == 1 && el);
    last_w = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 0; ext_req = 0; ext_lock = 0; cpu_wen = 0; ext_wen = 0;
    model_reset();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_ext_gnt", ext_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_ext_rvalid", ext_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_en", {mem_wen, mem_ren}, 0);
    check("rst_cpu_stall", cpu_stall, 0);
  endtask

  // Monitor: pops the owner's queue on every rvalid; idle ports must hold their rdata.
  logic [DATA_W-1:0] hold_cpu, hold_ext;
  initial begin
    exp_t e;
    hold_cpu = '0;
    hold_ext = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_cpu = '0;
        hold_ext = '0;
      end else begin
        if (cpu_rvalid) begin
          if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
          else begin
            e = cpu_q.pop_front();
            check("cpu_rdata", cpu_rdata, e.data);
            check("cpu_rd_latency", cyc, e.due);
          end
          hold_cpu = cpu_rdata;
        end else check("cpu_rdata_hold", cpu_rdata, hold_cpu);
        if (ext_rvalid) begin
          if (ext_q.size() == 0) check("ext_rvalid_unexpected", 1, 0);
          else begin
            e = ext_q.pop_front();
            check("ext_rdata", ext_rdata, e.data);
            check("ext_rd_latency", cyc, e.due);
          end
          hold_ext = ext_rdata;
        end else check("ext_rdata_hold", ext_rdata, hold_ext);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] rand_addr();
    return $urandom_range(0, 1) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom_range(1008, 1023));
  endfunction

  initial begin
    bit p_cpu, p_cw, er, ew, lk;
    logic [ADDR_W-1:0] p_ca, ea;
    logic [DATA_W-1:0] p_cd, ed;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1;
    cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_wen = 0; ext_addr = '0; ext_wdata = '0; ext_lock = 0;
    last_w = -1;
    model_reset();
    do_reset(3);

    // CPU-only read of 0x010 (seeded by a host write)
    step(0, 0, '0, '0, 1, 1, 10'h010, 32'hDEADBEEF, 0);
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
    check("t1_cpu_alone_granted", last_w, 0);
    idle(RD_LAT + 1);

    // Both read every cycle: CPU first after reset, then alternate
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, ADDR_W'(i), '0, 1, 0, ADDR_W'(1000 + i), '0, 0);
      check("t2_alternate", last_w, i % 2);
    end
    idle(RD_LAT + 1);

    // Host lock burst of 20 writes while the CPU keeps requesting
    step(1, 1, 10'h020, 32'h1111_0000, 0, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 10'h020, '0, 1, 1, ADDR_W'(10'h100 + i), $urandom, 1);
      check("t3_locked_host_grant", last_w, 1);
    end
    step(1, 0, 10'h020, '0, 0, 0, '0, '0, 0);
    check("t3_unlock_cycle_no_grant", last_w, -1);
    step(1, 0, 10'h020, '0, 1, 0, 10'h101, '0, 0);
    check("t3_cpu_after_unlock", last_w, 0);
    idle(RD_LAT + 1);

    // CPU saturates its wait counter during a lock, then wins immediately
    for (int i = 0; i < 3; i++) step(1, 0, 10'h005, '0, 1, 1, 10'h006, 32'hA5A5_0000 + i, 1);
    step(1, 0, 10'h005, '0, 1, 1, 10'h007, 32'h5A5A_5A5A, 0);
    step(1, 0, 10'h005, '0, 1, 0, 10'h007, '0, 0);
    check("t4_forced_grant", last_w, 0);
    step(1, 0, 10'h006, '0, 1, 0, 10'h007, '0, 0);
    check("t4_host_next", last_w, 1);
    idle(RD_LAT + 1);

    // Reset one cycle after a read grant drops the return
    step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
    do_reset(1);
    idle(RD_LAT + 2);

    // Top address write then read
    step(0, 0, '0, '0, 1, 1, 10'h3FF, 32'h1234_5678, 0);
    step(1, 0, 10'h3FF, '0, 0, 0, '0, '0, 0);
    check("t6_cpu_top_read_grant", last_w, 0);
    idle(RD_LAT + 1);

    // Randomized traffic; the CPU holds its request until granted
    p_cpu = 0; p_cw = 0; p_ca = '0; p_cd = '0; lk = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!p_cpu && $urandom_range(0, 99) < 55) begin
        p_cpu = 1;
        p_cw = 1'($urandom_range(0, 1));
        p_ca = rand_addr();
        p_cd = $urandom;
      end
      er = ($urandom_range(0, 99) < 50);
      ew = 1'($urandom_range(0, 1));
      ea = rand_addr();
      ed = $urandom;
      if ($urandom_range(0, 99) < 5) lk = ~lk;
      if ($urandom_range(0, 999) < 3) begin
        do_reset(1);
        p_cpu = 0;
        lk = 0;
      end else begin
        step(p_cpu, p_cw, p_ca, p_cd, er, ew, ea, ed, lk);
        if (last_w == 0) p_cpu = 0;
      end
    end
    idle(RD_LAT + 2);
    check("cpu_returns_outstanding", cpu_q.size(), 0);
    check("ext_returns_outstanding", ext_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
